uart_loader: RTL

Serial program loader: the receive-side counterpart to the CPU's debug UART transmitter. It samples an 8N1 line, assembles bytes little-endian into 32-bit words and issues one write per word to instruction/data memory at auto-incrementing byte addresses. An idle timeout ends a load session, so the board can be reprogrammed over the same USB-UART link used for debug output.

---
 rtl/uart_loader_pkg.sv | 29 ++
 rtl/uart_rx.sv | 152 +++++++++++++++
 rtl/uart_loader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the serial program loader.
// Receiver state encoding and the default bit period shared with the debug transmitter.
package uart_loader_pkg;

    localparam int          DEF_CLKS_PER_BIT = 234;
    localparam int          DEF_TIMEOUT_CLKS = 2_700_000;
    localparam logic [31:0] DEF_BASE_ADDR    = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

    // Place byte b into byte lane 'lane' of word w (little-endian).
    function automatic logic [31:0] lane_insert(
        input logic [31:0] w,
        input logic [1:0]  lane,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = w;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling FSM, bit timer and counter.
// Reports accepted bytes, stop-bit errors and start-bit events for the loader.
module uart_rx
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err,
    output logic       o_start_edge,
    output logic       o_start_ok,
    output logic       o_idle
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);

    logic            r_sync1;
    logic            r_sync2;
    rx_state_t       r_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_byte_valid;
    logic [7:0]      r_byte_data;
    logic            r_frame_err;

    rx_state_t       w_next;
    logic [TW-1:0]   w_timer;
    logic [2:0]      w_bitcnt;
    logic [7:0]      w_shift;
    logic            w_bv;
    logic            w_fe;
    logic [7:0]      w_data;
    logic            w_start_edge;
    logic            w_start_ok;
    logic            w_rx;

    assign w_rx = r_sync2;

    // Bring the asynchronous line into the clock domain (idle high).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Receiver state, timers, shift register and registered output pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_timer      <= w_timer;
            r_bitcnt     <= w_bitcnt;
            r_shift      <= w_shift;
            r_byte_valid <= w_bv;
            r_byte_data  <= w_data;
            r_frame_err  <= w_fe;
        end
    end

    // Next-state logic: half-bit check of the start bit, then one sample per bit period.
    always_comb begin
        w_next       = r_state;
        w_timer      = r_timer + TW'(1);
        w_bitcnt     = r_bitcnt;
        w_shift      = r_shift;
        w_bv         = 1'b0;
        w_fe         = 1'b0;
        w_data       = r_byte_data;
        w_start_edge = 1'b0;
        w_start_ok   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_timer = '0;
                if (!w_rx) begin
                    w_next       = ST_START;
                    w_start_edge = 1'b1;
                end
            end
            ST_START: begin
                if (r_timer == HALF) begin
                    w_timer = '0;
                    if (!w_rx) begin
                        w_next     = ST_DATA;
                        w_bitcnt   = '0;
                        w_start_ok = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (r_timer == FULL) begin
                    w_timer  = '0;
                    w_shift  = {w_rx, r_shift[7:1]};
                    w_bitcnt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (r_timer == FULL) begin
                    w_timer = '0;
                    if (w_rx) begin
                        w_bv   = 1'b1;
                        w_data = r_shift;
                        w_next = ST_IDLE;
                    end else begin
                        w_fe   = 1'b1;
                        w_next = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                w_timer = '0;
                if (w_rx) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_timer = '0;
                w_next  = ST_IDLE;
            end
        endcase
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte_data  = r_byte_data;
    assign o_frame_err  = r_frame_err;
    assign o_start_edge = w_start_edge;
    assign o_start_ok   = w_start_ok;
    assign o_idle       = (r_state == ST_IDLE);

endmodule

// File: rtl/uart_loader.sv
// Serial program loader: packs received bytes into little-endian words and
// writes them to memory at incrementing addresses; an idle timeout ends a session.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
    parameter int          TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        frame_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        load_done
);

    localparam int IW = ($clog2(TIMEOUT_CLKS) < 1) ? 1 : $clog2(TIMEOUT_CLKS);
    localparam logic [IW-1:0] LIMIT = IW'(TIMEOUT_CLKS - 1);

    logic          w_bv;
    logic [7:0]    w_byte;
    logic          w_fe;
    logic          w_start_edge;
    logic          w_start_ok;
    logic          w_idle;
    logic          w_timeout;

    logic [1:0]    r_lane;
    logic [31:0]   r_word;
    logic          r_we;
    logic [31:0]   r_wdata;
    logic [31:0]   r_addr;
    logic          r_busy;
    logic          r_done;
    logic [IW-1:0] r_idle_cnt;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx         (uart_rx),
        .o_byte_valid (w_bv),
        .o_byte_data  (w_byte),
        .o_frame_err  (w_fe),
        .o_start_edge (w_start_edge),
        .o_start_ok   (w_start_ok),
        .o_idle       (w_idle)
    );

    // A start edge in the same cycle beats the timeout.
    assign w_timeout = r_busy && w_idle && !w_start_edge && (r_idle_cnt == LIMIT);

    // Byte packer: fills lanes 0..3, then emits the word with a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane  <= '0;
            r_word  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_fe || w_timeout) begin
                r_lane <= '0;
                r_word <= '0;
            end else if (w_bv) begin
                r_word <= lane_insert(r_word, r_lane, w_byte);
                r_lane <= r_lane + 2'd1;
                if (r_lane == 2'd3) begin
                    r_we    <= 1'b1;
                    r_wdata <= lane_insert(r_word, r_lane, w_byte);
                end
            end
        end
    end

    // Address counter: advances after each write strobe, rewinds on session end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= BASE_ADDR;
        end else if (w_timeout) begin
            r_addr <= BASE_ADDR;
        end else if (r_we) begin
            r_addr <= r_addr + 32'd4;
        end
    end

    // Session tracking: busy from first accepted start bit until the idle timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_busy <= 1'b1;
            end
            if (w_start_edge || !r_busy || !w_idle) begin
                r_idle_cnt <= '0;
            end else if (w_timeout) begin
                r_idle_cnt <= '0;
                r_done     <= 1'b1;
                r_busy     <= 1'b0;
            end else begin
                r_idle_cnt <= r_idle_cnt + IW'(1);
            end
        end
    end

    assign byte_valid = w_bv;
    assign byte_data  = w_byte;
    assign frame_err  = w_fe;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign busy       = r_busy;
    assign load_done  = r_done;

endmodule
